// File: rtl/q_weight_update_d_pkg.sv
// Shared types and constants for the spline-filter Q-weight update engine.
// Fixed-point defaults, index-width helper and the update FSM encoding.
package q_weight_update_d_pkg;

    localparam int QW_WIDTH = 16;
    localparam int QW_FRAC  = 13;

    function automatic int one_of(input int frac);
        return 1 << frac;
    endfunction

    localparam int QW_ONE = one_of(QW_FRAC);

    function automatic int sidx_w(input int q, input int q_ord);
        return $clog2(q + q_ord);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_U2,
        ST_U3,
        ST_MUE,
        ST_BASIS,
        ST_MAC,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/q_weight_update_d_mul.sv
// Signed fixed-point multiply: round half up, drop FRAC bits, saturate.
// Purely combinational; the engine time-shares one instance.
module fxp_mul_sat #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 13
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);

    localparam int PW = 2 * WIDTH + 1;
    localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC - 1);

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;
    logic signed [PW-1:0] sh;
    logic [PW-WIDTH:0]    top;

    assign prod = PW'(a) * PW'(b);
    assign rnd  = prod + HALF;
    assign sh   = rnd >>> FRAC;
    assign top  = sh[PW-1:WIDTH-1];

    always_comb begin
        if (&top || ~|top) begin
            y = sh[WIDTH-1:0];
        end else if (sh[PW-1]) begin
            y = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            y = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/q_weight_update_d.sv
// Sequential Catmull-Rom weight update for the spline filter Q store.
// Only the COMMIT cycle writes new data; all other cycles pass old weights through.
module q_weight_update_d
    import q_weight_update_d_pkg::*;
#(
    parameter int WIDTH = QW_WIDTH,
    parameter int FRAC  = QW_FRAC,
    parameter int Q     = 13,
    parameter int Q_ORD = 4,
    localparam int SIDX = sidx_w(Q, Q_ORD)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       e_in,
    input  logic [WIDTH-1:0]       mu_in,
    input  logic [WIDTH-1:0]       u_in,
    input  logic [SIDX-1:0]        span_ind_in,
    input  logic [Q_ORD*WIDTH-1:0] q_weight_old_packed,
    output logic [SIDX-1:0]        span_ind_write,
    output logic [SIDX-1:0]        span_ind_write_d,
    output logic [Q_ORD*WIDTH-1:0] q_update_packed,
    output logic                   busy,
    output logic                   done
);

    localparam int XW  = WIDTH + 3;
    localparam int ONE = (FRAC == QW_FRAC) ? QW_ONE : one_of(FRAC);
    localparam logic signed [XW-1:0] ONE2 = XW'(2 * ONE);

    typedef logic signed [WIDTH-1:0] fx_t;

    localparam fx_t FX_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam fx_t FX_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t          state;
    logic [1:0]      k;
    logic [SIDX-1:0] span_r;
    fx_t             e_r, mu_r, u_r;
    fx_t             u2_r, u3_r, mue_r;
    fx_t             g_r  [Q_ORD];
    fx_t             qn_r [Q_ORD];
    fx_t             q_old [Q_ORD];
    fx_t             mul_a, mul_b, mul_y;

    logic signed [XW-1:0] x1, x2, x3;
    logic signed [XW-1:0] b0, b1, b2, b3;
    logic signed [XW-1:0] mac_sum;

    function automatic fx_t sat_x(input logic signed [XW-1:0] v);
        logic [XW-WIDTH:0] hi;
        hi = v[XW-1:WIDTH-1];
        if (&hi || ~|hi) begin
            return v[WIDTH-1:0];
        end
        return v[XW-1] ? FX_MIN : FX_MAX;
    endfunction

    always_comb begin
        for (int i = 0; i < Q_ORD; i++) begin
            q_old[i] = q_weight_old_packed[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state)
            ST_U2:   begin mul_a = u_r;   mul_b = u_r;    end
            ST_U3:   begin mul_a = u2_r;  mul_b = u_r;    end
            ST_MUE:  begin mul_a = mu_r;  mul_b = e_r;    end
            ST_MAC:  begin mul_a = mue_r; mul_b = g_r[k]; end
            default: ;
        endcase
    end

    fxp_mul_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mul (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    // Basis polynomials in shift/add form, halved arithmetically
    assign x1 = XW'(u_r);
    assign x2 = XW'(u2_r);
    assign x3 = XW'(u3_r);
    assign b0 = (-x3 + (x2 <<< 1) - x1) >>> 1;
    assign b1 = (x3 + (x3 <<< 1) - x2 - (x2 <<< 2) + ONE2) >>> 1;
    assign b2 = (-x3 - (x3 <<< 1) + (x2 <<< 2) + x1) >>> 1;
    assign b3 = (x3 - x2) >>> 1;

    assign mac_sum = XW'(q_old[k]) + XW'(mul_y);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            k      <= 2'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            span_r <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        e_r    <= e_in;
                        mu_r   <= mu_in;
                        u_r    <= u_in;
                        span_r <= (span_ind_in > SIDX'(Q - 1))
                                  ? SIDX'(Q - 1) : span_ind_in;
                        k      <= 2'd0;
                        busy   <= 1'b1;
                        state  <= ST_U2;
                    end
                end
                ST_U2: begin
                    u2_r  <= mul_y;
                    state <= ST_U3;
                end
                ST_U3: begin
                    u3_r  <= mul_y;
                    state <= ST_MUE;
                end
                ST_MUE: begin
                    mue_r <= mul_y;
                    state <= ST_BASIS;
                end
                ST_BASIS: begin
                    g_r[0] <= sat_x(b0);
                    g_r[1] <= sat_x(b1);
                    g_r[2] <= sat_x(b2);
                    g_r[3] <= sat_x(b3);
                    state  <= ST_MAC;
                end
                ST_MAC: begin
                    qn_r[k] <= sat_x(mac_sum);
                    k       <= k + 2'd1;
                    if (k == 2'd3) begin
                        done  <= 1'b1;
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        q_update_packed = q_weight_old_packed;
        if (state == ST_COMMIT) begin
            for (int i = 0; i < Q_ORD; i++) begin
                q_update_packed[i*WIDTH +: WIDTH] = qn_r[i];
            end
        end
    end

    assign span_ind_write   = span_r;
    assign span_ind_write_d = span_r;

endmodule

// File: tb/tb_q_weight_update_d.sv
// Bench for q_weight_update_d: controller model plus arithmetic reference.
// Directed cases followed by randomized updates.
module tb_q_weight_update_d;

    localparam int WIDTH = 16;
    localparam int Q_ORD = 4;
    localparam int SIDX  = 5;
    localparam int NQ    = 41;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [WIDTH-1:0]       e_in, mu_in, u_in;
    logic [SIDX-1:0]        span_ind_in;
    logic [Q_ORD*WIDTH-1:0] q_weight_old_packed;
    logic [SIDX-1:0]        span_ind_write, span_ind_write_d;
    logic [Q_ORD*WIDTH-1:0] q_update_packed;
    logic                   busy, done;

    logic [15:0] ctrl  [0:NQ-1];
    logic [15:0] exp_q [0:NQ-1];
    logic        ld;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    q_weight_update_d dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .e_in                (e_in),
        .mu_in               (mu_in),
        .u_in                (u_in),
        .span_ind_in         (span_ind_in),
        .q_weight_old_packed (q_weight_old_packed),
        .span_ind_write      (span_ind_write),
        .span_ind_write_d    (span_ind_write_d),
        .q_update_packed     (q_update_packed),
        .busy                (busy),
        .done                (done)
    );

    always_comb begin
        for (int k = 0; k < Q_ORD; k++) begin
            q_weight_old_packed[k*16 +: 16] = ctrl[int'(span_ind_write_d) + k];
        end
    end

    // Controller: writes four lanes at the requested span on every edge
    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < NQ; i++) ctrl[i] <= 16'hE800 + 16'(i) * 16'h0400;
        end else begin
            for (int k = 0; k < Q_ORD; k++) begin
                ctrl[int'(span_ind_write_d) + k] <= q_update_packed[k*16 +: 16];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clamp(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int fxmul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b) + 64'sd4096;
        return clamp(p >>> 13);
    endfunction

    task automatic model_update(input logic [15:0] e, input logic [15:0] mu,
                                input logic [15:0] u, input int span);
        int sp, uu, u2, u3, mue;
        int g [4];
        sp  = (span > 12) ? 12 : span;
        uu  = s16(u);
        u2  = fxmul(uu, uu);
        u3  = fxmul(u2, uu);
        mue = fxmul(s16(mu), s16(e));
        g[0] = clamp((-u3 + 2 * u2 - uu) >>> 1);
        g[1] = clamp((3 * u3 - 5 * u2 + 2 * 8192) >>> 1);
        g[2] = clamp((-3 * u3 + 4 * u2 + uu) >>> 1);
        g[3] = clamp((u3 - u2) >>> 1);
        for (int k = 0; k < 4; k++) begin
            exp_q[sp + k] = 16'(clamp(longint'(s16(exp_q[sp + k])) + fxmul(mue, g[k])));
        end
    endtask

    task automatic cmp_store(input string tag);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("%s_q%0d", tag, i), 64'(ctrl[i]), 64'(exp_q[i]));
        end
    endtask

    task automatic run(input logic [15:0] e, input logic [15:0] mu,
                       input logic [15:0] u, input logic [4:0] sp,
                       input int hold, input int nacc, input string tag);
        bit d_ok, b_ok;
        int spe;
        spe = (int'(sp) > 12) ? 12 : int'(sp);
        for (int a = 0; a < nacc; a++) model_update(e, mu, u, int'(sp));
        @(negedge clk);
        start = 1'b1; e_in = e; mu_in = mu; u_in = u; span_ind_in = sp;
        d_ok = 1'b1;
        b_ok = 1'b1;
        for (int n = 1; n <= 10 * nacc; n++) begin
            @(negedge clk);
            if (n == hold) start = 1'b0;
            if (n == 1) begin
                chk({tag, "_span"}, 64'(span_ind_write), 64'(spe));
                chk({tag, "_span_d"}, 64'(span_ind_write_d), 64'(spe));
            end
            d_ok &= (done === (n % 10 == 9));
            b_ok &= (busy === (n % 10 != 0));
        end
        chk({tag, "_done_timing"}, 64'(d_ok), 64'd1);
        chk({tag, "_busy_timing"}, 64'(b_ok), 64'd1);
        @(negedge clk);
        cmp_store(tag);
    endtask

    initial begin
        bit pt_ok;
        reset = 1'b1; ld = 1'b1; start = 1'b0;
        e_in = '0; mu_in = '0; u_in = '0; span_ind_in = '0;
        for (int i = 0; i < NQ; i++) exp_q[i] = 16'hE800 + 16'(i) * 16'h0400;
        repeat (3) @(negedge clk);
        ld = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_span", 64'(span_ind_write), 64'd0);
        chk("rst_pass", q_update_packed, q_weight_old_packed);
        reset = 1'b0;

        run(16'h0800, 16'h1000, 16'h0000, 5'd6, 1, 1, "c1");
        chk("c1_lane0", 64'(ctrl[6]), 64'h0000);
        chk("c1_lane1", 64'(ctrl[7]), 64'h0800);
        chk("c1_lane2", 64'(ctrl[8]), 64'h0800);
        chk("c1_lane3", 64'(ctrl[9]), 64'h0C00);

        run(16'h0800, 16'h1000, 16'h1000, 5'd0, 1, 1, "c2");
        chk("c2_q0", 64'(ctrl[0]), 64'hE7C0);
        chk("c2_q1", 64'(ctrl[1]), 64'hEE40);
        chk("c2_q2", 64'(ctrl[2]), 64'hF240);
        chk("c2_q3", 64'(ctrl[3]), 64'hF3C0);

        run(16'h7FFF, 16'h7FFF, 16'h0000, 5'd12, 1, 1, "c3");
        chk("c3_q13", 64'(ctrl[13]), 64'h7FFF);
        chk("c3_q12", 64'(ctrl[12]), 64'h1800);
        chk("c3_q14", 64'(ctrl[14]), 64'h2000);
        chk("c3_q15", 64'(ctrl[15]), 64'h2400);

        run(16'h0100, 16'h0200, 16'h0A00, 5'd15, 20, 2, "c4");

        // Abort an update mid-MAC
        @(negedge clk);
        start = 1'b1; e_in = 16'h0400; mu_in = 16'h0800;
        u_in = 16'h0C00; span_ind_in = 5'd3;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 6) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        chk("c5_busy", 64'(busy), 64'd0);
        chk("c5_done", 64'(done), 64'd0);
        chk("c5_span", 64'(span_ind_write), 64'd0);
        repeat (12) @(negedge clk);
        cmp_store("c5_abort");
        run(16'h0400, 16'h0800, 16'h0C00, 5'd3, 1, 1, "c5_rerun");

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pt_ok = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            pt_ok &= (q_update_packed === q_weight_old_packed);
            chk($sformatf("c6_pass%0d", n), q_update_packed, q_weight_old_packed);
        end
        chk("c6_pass_all", 64'(pt_ok), 64'd1);
        cmp_store("c6");

        for (int r = 0; r < 8; r++) begin
            run(16'($urandom), 16'($urandom), 16'($urandom_range(0, 8191)),
                5'($urandom_range(0, 15)), 1, 1, $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
